// File: rtl/lsu_rmw_if.sv
// Request/response handshake and data-memory port bundle for lsu_rmw.
interface lsu_rmw_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_err_code;
    logic [63:0] mem_A;
    logic [63:0] mem_WD;
    logic        mem_WE;
    logic [63:0] mem_RD;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code,
        output mem_A, mem_WD, mem_WE
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_err_code,
        input  mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/lsu_rmw.sv
// RV64 load/store unit over a 64-bit word memory; sub-word stores use read-modify-write.
// Optional: define MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module lsu_rmw #(
    parameter logic [63:0] ADDR_LIMIT  = 64'd8000,
    parameter logic [63:0] RESET_RDATA = 64'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_rmw_if.slave   bus
);
    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state;
    logic [63:0] merge_q, addr_q;

    logic        accept, illegal, misal, afault, fault, sub_st;
    logic [1:0]  sz, code;
    logic [3:0]  nbytes;
    logic [2:0]  amask;
    logic [5:0]  sh;
    logic [63:0] eaddr, lane, ext, mask, merged;
    logic [64:0] end_addr;

    always_comb begin
        sz      = bus.req_funct3[1:0];
        nbytes  = 4'd1 << sz;
        amask   = 3'(nbytes - 4'd1);
        illegal = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
`ifdef MISALIGN_TRAP_EN
        misal   = (bus.req_addr[2:0] & amask) != 3'd0;
        eaddr   = bus.req_addr;
`else
        misal   = 1'b0;
        eaddr   = {bus.req_addr[63:3], bus.req_addr[2:0] & ~amask};
`endif
        // 65-bit sum so addresses near 2^64 cannot wrap past the limit check
        end_addr = {1'b0, eaddr} + 65'(nbytes);
        afault   = end_addr > {1'b0, ADDR_LIMIT};
        if (illegal)     code = 2'd3;
        else if (misal)  code = 2'd1;
        else if (afault) code = 2'd2;
        else             code = 2'd0;
        fault  = code != 2'd0;
        accept = bus.req_valid && (state == IDLE);
        sub_st = bus.req_we && (sz != 2'd3);

        sh   = {eaddr[2:0], 3'b000};
        lane = bus.mem_RD >> sh;
        case (sz)
            2'd0:    ext = bus.req_funct3[2] ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            2'd1:    ext = bus.req_funct3[2] ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            2'd2:    ext = bus.req_funct3[2] ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default: ext = lane;
        endcase
        case (sz)
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = '1;
        endcase
        mask   = mask << sh;
        merged = (bus.mem_RD & ~mask) | ((bus.req_wdata << sh) & mask);

        bus.req_ready = (state == IDLE);
        bus.mem_A     = '0;
        bus.mem_WD    = '0;
        bus.mem_WE    = 1'b0;
        if (state == IDLE) begin
            bus.mem_A = {bus.req_addr[63:3], 3'b000};
            if (accept && bus.req_we && !fault && !sub_st) begin
                bus.mem_WE = 1'b1;
                bus.mem_WD = bus.req_wdata;
            end
        end else begin
            bus.mem_A  = addr_q;
            bus.mem_WD = merge_q;
            bus.mem_WE = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            merge_q          <= '0;
            addr_q           <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_err      <= 1'b0;
            bus.rsp_err_code <= 2'd0;
            bus.rsp_rdata    <= RESET_RDATA;
        end else begin
            bus.rsp_valid    <= 1'b0;
            bus.rsp_err      <= 1'b0;
            bus.rsp_err_code <= 2'd0;
            case (state)
                IDLE: if (accept) begin
                    if (fault) begin
                        bus.rsp_valid    <= 1'b1;
                        bus.rsp_err      <= 1'b1;
                        bus.rsp_err_code <= code;
                    end else if (!bus.req_we) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= ext;
                    end else if (sub_st) begin
                        merge_q <= merged;
                        addr_q  <= {eaddr[63:3], 3'b000};
                        state   <= WRITE;
                    end else begin
                        bus.rsp_valid <= 1'b1;
                    end
                end
                WRITE: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
